// File: rtl/mc_core_ctrl.sv
// Multi-cycle RV32 control sequencer: FETCH/DECODE/EXEC/MEM/WB/TRAP with req/ready memory handshakes.
// Latency 3-5 cycles per instruction plus memory wait; a memory ready held low past the timeout traps.
module mc_core_ctrl #(
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 zero,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 imem_req,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [1:0]           result_src,
    output logic                 reg_write,
    output logic [2:0]           state,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic [CNT_WIDTH-1:0] retired
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t                 state_q, state_d;
    logic [WW-1:0]          wait_q, wait_d;
    logic                   trap_q;
    logic [1:0]             cause_q, cause_d;
    logic [CNT_WIDTH-1:0]   retired_q;
    logic                   retire;
    logic                   timed_out;
    logic                   imem_req_c, ir_write_c, pc_write_c, dmem_req_c, dmem_we_c, reg_write_c;

    assign timed_out = (TIMEOUT_CYCLES > 0) && (wait_q == WAIT_LAST);

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        cause_d     = cause_q;
        retire      = 1'b0;
        imem_req_c  = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        dmem_req_c  = 1'b0;
        dmem_we_c   = 1'b0;
        reg_write_c = 1'b0;
        pc_src      = 1'b0;
        alu_src_a   = 2'd0;
        alu_src_b   = 2'd0;
        alu_op      = 2'b00;
        result_src  = 2'd0;
        case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end else if (timed_out) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R, OP_I, OP_LD, OP_ST, OP_JAL: state_d = S_EXEC;
                    OP_BR: begin
                        if (funct3 == 3'b000 || funct3 == 3'b001) begin
                            state_d = S_EXEC;
                        end else begin
                            state_d = S_TRAP;
                            cause_d = 2'b01;
                        end
                    end
                    default: begin
                        state_d = S_TRAP;
                        cause_d = 2'b01;
                    end
                endcase
            end
            S_EXEC: begin
                case (opcode)
                    OP_R: begin
                        alu_op  = 2'b10;
                        state_d = S_WB;
                    end
                    OP_I: begin
                        alu_src_b = 2'd1;
                        alu_op    = 2'b10;
                        state_d   = S_WB;
                    end
                    OP_LD, OP_ST: begin
                        alu_src_b = 2'd1;
                        state_d   = S_MEM;
                    end
                    OP_BR: begin
                        alu_op     = 2'b01;
                        pc_write_c = (funct3 == 3'b000) ? zero : !zero;
                        pc_src     = 1'b1;
                        retire     = 1'b1;
                        state_d    = S_FETCH;
                    end
                    OP_JAL: begin
                        pc_write_c = 1'b1;
                        pc_src     = 1'b1;
                        state_d    = S_WB;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (opcode == OP_ST);
                if (dmem_ready) begin
                    if (opcode == OP_LD) begin
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (timed_out) begin
                    state_d = S_TRAP;
                    cause_d = 2'b11;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_WB: begin
                reg_write_c = 1'b1;
                if (opcode == OP_LD)
                    result_src = 2'd1;
                else if (opcode == OP_JAL)
                    result_src = 2'd2;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
        if (state_d != state_q)
            wait_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            trap_q    <= 1'b0;
            cause_q   <= 2'b00;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
            if (state_d == S_TRAP)
                trap_q <= 1'b1;
            if (retire)
                retired_q <= retired_q + CNT_WIDTH'(1);
        end
    end

    // Strobes are combinational, so gate them while reset is being applied mid-instruction.
    assign imem_req   = imem_req_c  & ~rst;
    assign ir_write   = ir_write_c  & ~rst;
    assign pc_write   = pc_write_c  & ~rst;
    assign dmem_req   = dmem_req_c  & ~rst;
    assign dmem_we    = dmem_we_c   & ~rst;
    assign reg_write  = reg_write_c & ~rst;
    assign state      = state_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign retired    = retired_q;
endmodule

// File: tb/tb_mc_core_ctrl.sv
// Bench for mc_core_ctrl: per-cycle expected outputs are queued as stimulus is driven
// and compared on the falling edge.
module tb_mc_core_ctrl;
    localparam int TO = 4;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_T = 3'd5;

    logic       clk = 1'b0;
    logic       rst, zero, imem_ready, dmem_ready;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       imem_req, ir_write, pc_write, pc_src, dmem_req, dmem_we, reg_write, trap;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, trap_cause;
    logic [2:0] state, retired;

    always #5 clk = ~clk;

    mc_core_ctrl #(.CNT_WIDTH(3), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .result_src(result_src),
        .reg_write(reg_write), .state(state), .trap(trap), .trap_cause(trap_cause),
        .retired(retired)
    );

    // strb = {imem_req, ir_write, pc_write, dmem_req, dmem_we, reg_write}
    // mux  = {pc_src, alu_src_a, alu_src_b, alu_op, result_src}
    typedef struct packed {
        logic [2:0] st;
        logic [5:0] strb;
        logic [8:0] mux;
        logic [2:0] tr;
        logic [2:0] ret;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         nvec = 0, nerr = 0, exp_ret = 0;
    logic [6:0] nop;
    logic [2:0] nf3;
    logic       nz;
    logic [1:0] tc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] st, input logic [5:0] strb,
                                input logic [8:0] mux, input logic [2:0] tr);
        exp_t e;
        e.st = st; e.strb = strb; e.mux = mux; e.tr = tr; e.ret = 3'(exp_ret);
        return e;
    endfunction

    task automatic step(input logic r, input logic ir, input logic dr, input exp_t e);
        @(posedge clk); #1;
        rst = r; imem_ready = ir; dmem_ready = dr;
        opcode = nop; funct3 = nf3; zero = nz;
        exp_q.push_back(e);
    endtask

    task automatic bump;
        exp_ret = (exp_ret + 1) % 8;
    endtask

    // Drives one instruction; stray readies are applied in states that must ignore them.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                             input int iw, input int dw, output logic [1:0] cause);
        logic [5:0] ms;
        logic       take;
        cause = 2'b00;
        nop = op; nf3 = f3; nz = z;
        for (int i = 0; i < iw; i++) begin
            if (i == TO) begin cause = 2'b10; return; end
            step(1'b0, 1'b0, 1'b1, mk(S_F, 6'b100000, 9'b0, 3'b0));
        end
        step(1'b0, 1'b1, 1'b1, mk(S_F, 6'b111000, 9'b0, 3'b0));
        step(1'b0, 1'b1, 1'b1, mk(S_D, 6'b0, 9'b0, 3'b0));
        if (!(op inside {OP_R, OP_I, OP_LD, OP_ST, OP_JAL}) &&
            !(op == OP_BR && (f3 == 3'b000 || f3 == 3'b001))) begin
            cause = 2'b01;
            return;
        end
        case (op)
            OP_R: begin
                step(1'b0, 1'b1, 1'b0, mk(S_E, 6'b0, 9'b0_00_00_10_00, 3'b0));
                step(1'b0, 1'b0, 1'b0, mk(S_W, 6'b000001, 9'b0, 3'b0)); bump();
            end
            OP_I: begin
                step(1'b0, 1'b1, 1'b0, mk(S_E, 6'b0, 9'b0_00_01_10_00, 3'b0));
                step(1'b0, 1'b0, 1'b0, mk(S_W, 6'b000001, 9'b0, 3'b0)); bump();
            end
            OP_BR: begin
                take = (f3 == 3'b000) ? z : !z;
                step(1'b0, 1'b1, 1'b1, mk(S_E, take ? 6'b001000 : 6'b0, 9'b1_00_00_01_00, 3'b0));
                bump();
            end
            OP_JAL: begin
                step(1'b0, 1'b1, 1'b0, mk(S_E, 6'b001000, 9'b1_00_00_00_00, 3'b0));
                step(1'b0, 1'b0, 1'b0, mk(S_W, 6'b000001, 9'b0_00_00_00_10, 3'b0)); bump();
            end
            default: begin
                ms = (op == OP_ST) ? 6'b000110 : 6'b000100;
                step(1'b0, 1'b1, 1'b1, mk(S_E, 6'b0, 9'b0_00_01_00_00, 3'b0));
                for (int i = 0; i < dw; i++) begin
                    if (i == TO) begin cause = 2'b11; return; end
                    step(1'b0, 1'b1, 1'b0, mk(S_M, ms, 9'b0, 3'b0));
                end
                step(1'b0, 1'b0, 1'b1, mk(S_M, ms, 9'b0, 3'b0));
                if (op == OP_ST) begin
                    bump();
                end else begin
                    step(1'b0, 1'b0, 1'b0, mk(S_W, 6'b000001, 9'b0_00_00_00_01, 3'b0)); bump();
                end
            end
        endcase
    endtask

    // Runs an instruction; any trap is held for 20 cycles and then cleared by reset.
    task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                         input int iw, input int dw);
        run_instr(op, f3, z, iw, dw, tc);
        if (tc != 2'b00) begin
            for (int i = 0; i < 20; i++)
                step(1'b0, 1'b1, 1'b1, mk(S_T, 6'b0, 9'b0, {1'b1, tc}));
            step(1'b1, 1'b0, 1'b0, mk(S_T, 6'b0, 9'b0, {1'b1, tc}));
            exp_ret = 0;
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("state", 32'(state), 32'(mon_e.st));
            chk("strobes", 32'({imem_req, ir_write, pc_write, dmem_req, dmem_we, reg_write}),
                32'(mon_e.strb));
            chk("muxes", 32'({pc_src, alu_src_a, alu_src_b, alu_op, result_src}), 32'(mon_e.mux));
            chk("trap", 32'({trap, trap_cause}), 32'(mon_e.tr));
            chk("retired", 32'(retired), 32'(mon_e.ret));
        end
    end

    initial begin
        rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; zero = 1'b0;
        opcode = OP_R; funct3 = 3'b0; nop = OP_R; nf3 = 3'b0; nz = 1'b0;
        repeat (2) @(posedge clk);
        step(1'b1, 1'b0, 1'b0, mk(S_F, 6'b0, 9'b0, 3'b0));

        instr(OP_R,   3'b000, 1'b0, 0, 0);
        instr(OP_I,   3'b000, 1'b0, 2, 0);
        instr(OP_LD,  3'b010, 1'b0, 0, 3);
        instr(OP_ST,  3'b010, 1'b0, 1, 1);
        instr(OP_BR,  3'b000, 1'b1, 0, 0);
        instr(OP_BR,  3'b001, 1'b1, 0, 0);
        instr(OP_BR,  3'b000, 1'b0, 0, 0);
        instr(OP_BR,  3'b001, 1'b0, 0, 0);
        instr(OP_JAL, 3'b000, 1'b0, 0, 0);
        instr(OP_R,   3'b000, 1'b0, 3, 0);
        instr(7'b1111111, 3'b000, 1'b0, 0, 0);
        instr(OP_BR,  3'b010, 1'b0, 0, 0);
        instr(OP_R,   3'b000, 1'b0, 10, 0);
        instr(OP_LD,  3'b000, 1'b0, 0, 10);
        for (int i = 0; i < 9; i++)
            instr(OP_BR, 3'b000, 1'b1, 0, 0);

        // Reset asserted while a load is waiting in MEM, with a stray dmem_ready.
        nop = OP_LD; nf3 = 3'b010; nz = 1'b0;
        step(1'b0, 1'b1, 1'b0, mk(S_F, 6'b111000, 9'b0, 3'b0));
        step(1'b0, 1'b0, 1'b0, mk(S_D, 6'b0, 9'b0, 3'b0));
        step(1'b0, 1'b0, 1'b0, mk(S_E, 6'b0, 9'b0_00_01_00_00, 3'b0));
        step(1'b0, 1'b0, 1'b0, mk(S_M, 6'b000100, 9'b0, 3'b0));
        step(1'b1, 1'b0, 1'b1, mk(S_M, 6'b0, 9'b0, 3'b0));
        exp_ret = 0;
        instr(OP_R, 3'b000, 1'b0, 0, 0);

        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
